dvp_frame_tx: RTL and testbench

Regenerates an OV5640-style DVP video interface (vsync, href, 8-bit data) from a 16-bit RGB565 pixel stream. It is the transmit counterpart to the camera capture and 8→16 packing path. It is used as a camera emulator for loopback and simulation, and to drive a second board's DVP input. The block pulls pixels with a valid/ready handshake and splits each pixel into two bytes, high byte first.

---
 rtl/dvp_pkg.sv | 22 ++
 rtl/dvp_timing_gen.sv | 107 ++++++++++
 rtl/dvp_frame_tx.sv | 77 +++++++
 tb/tb_dvp_frame_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP frame transmitter.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    localparam bit BYTE_HI_FIRST = 1'b1;

    function automatic int line_total(input int w, input int hb);
        return 2 * w + hb;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line sequencer: byte and line counters plus the vsync/back/active/front FSM.
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int IMAGE_W  = 1280,
    parameter int IMAGE_H  = 720,
    parameter int H_BLANK  = 64,
    parameter int VS_LINES = 4,
    parameter int V_BACK   = 8,
    parameter int V_FRONT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic vsync_o,
    output logic href_o,
    output logic slot_odd_o,
    output logic frame_done_o,
    output logic pix_req_o
);

    localparam int LINE_T    = line_total(IMAGE_W, H_BLANK);
    localparam int ACT_BYTES = 2 * IMAGE_W;
    localparam int MAX_LINES = max_int(max_int(IMAGE_H, VS_LINES), max_int(V_BACK, V_FRONT));
    localparam int BYTE_W    = $clog2(LINE_T);
    localparam int LINE_W    = $clog2(MAX_LINES + 1);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   last_line;
    logic                line_end, phase_end, next_line_active;

    always_comb begin
        last_line = '0;
        unique case (state_q)
            VSYNC:   last_line = LINE_W'(VS_LINES - 1);
            VBACK:   last_line = LINE_W'(V_BACK - 1);
            ACTIVE:  last_line = LINE_W'(IMAGE_H - 1);
            VFRONT:  last_line = LINE_W'(V_FRONT - 1);
            default: last_line = '0;
        endcase
    end

    assign line_end  = (byte_q == BYTE_W'(LINE_T - 1));
    assign phase_end = line_end && (line_q == last_line);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        line_d       = line_q;
        frame_done_o = 1'b0;
        if (state_q == IDLE) begin
            byte_d = '0;
            line_d = '0;
            if (enable_i) state_d = VSYNC;
        end else begin
            byte_d = line_end ? '0 : byte_q + 1'b1;
            if (line_end) line_d = line_q + 1'b1;
            if (phase_end) begin
                line_d = '0;
                unique case (state_q)
                    VSYNC:  state_d = (V_BACK > 0) ? VBACK : ACTIVE;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: begin
                        if (V_FRONT > 0) begin
                            state_d = VFRONT;
                        end else begin
                            frame_done_o = 1'b1;
                            state_d      = enable_i ? VSYNC : IDLE;
                        end
                    end
                    VFRONT: begin
                        frame_done_o = 1'b1;
                        state_d      = enable_i ? VSYNC : IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            byte_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
        end
    end

    // Request looks two cycles ahead: it is registered once more before reaching pix_ready.
    assign next_line_active = (line_q != last_line) ? (state_q == ACTIVE)
                            : ((state_q == VBACK) || (state_q == VSYNC && V_BACK == 0));
    assign pix_req_o = (state_q == ACTIVE && !byte_q[0] && byte_q < BYTE_W'(ACT_BYTES - 2))
                    || (byte_q == BYTE_W'(LINE_T - 2) && next_line_active);

    assign vsync_o    = (state_q == VSYNC);
    assign href_o     = (state_q == ACTIVE) && (byte_q < BYTE_W'(ACT_BYTES));
    assign slot_odd_o = byte_q[0];

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP transmitter: pulls RGB565 pixels and serialises them as two bytes per pixel.
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int IMAGE_W  = 1280,
    parameter int IMAGE_H  = 720,
    parameter int H_BLANK  = 64,
    parameter int VS_LINES = 4,
    parameter int V_BACK   = 8,
    parameter int V_FRONT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_done,
    output logic        underflow
);

    logic        pix_req, slot_odd;
    logic        pix_ready_q;
    logic [15:0] pix_q, pix_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  first_byte, second_byte;

    dvp_timing_gen #(
        .IMAGE_W  (IMAGE_W),
        .IMAGE_H  (IMAGE_H),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .vsync_o      (cmos_vsync),
        .href_o       (cmos_href),
        .slot_odd_o   (slot_odd),
        .frame_done_o (frame_done),
        .pix_req_o    (pix_req)
    );

    // A missing pixel is replaced by black so line timing never stretches.
    always_comb begin
        pix_d       = pix_q;
        underflow_d = underflow_q;
        if (pix_ready_q) begin
            pix_d = pix_valid ? pix_data : 16'h0000;
            if (!pix_valid) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_ready_q <= 1'b0;
            pix_q       <= 16'h0000;
            underflow_q <= 1'b0;
        end else begin
            pix_ready_q <= pix_req;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    assign first_byte  = BYTE_HI_FIRST ? pix_q[15:8] : pix_q[7:0];
    assign second_byte = BYTE_HI_FIRST ? pix_q[7:0]  : pix_q[15:8];
    assign cmos_data   = !cmos_href ? 8'h00 : (slot_odd ? second_byte : first_byte);
    assign pix_ready   = pix_ready_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Bench for dvp_frame_tx: position-in-frame reference model checked every cycle plus directed scenarios.
module tb_dvp_frame_tx;

    localparam int IMAGE_W  = 4;
    localparam int IMAGE_H  = 2;
    localparam int H_BLANK  = 4;
    localparam int VS_LINES = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;
    localparam int LINE_T   = 2 * IMAGE_W + H_BLANK;
    localparam int FRAME_T  = (VS_LINES + V_BACK + IMAGE_H + V_FRONT) * LINE_T;

    logic        clk = 1'b0;
    logic        rst_n, enable, pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready, cmos_vsync, cmos_href, frame_done, underflow;
    logic [7:0]  cmos_data;

    always #5 clk = ~clk;

    dvp_frame_tx #(
        .IMAGE_W  (IMAGE_W),
        .IMAGE_H  (IMAGE_H),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_data  (cmos_data),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          pos;            // cycle index within the current frame, -1 when idle
    logic        m_ready, m_uf;
    logic [15:0] m_pix;
    logic [15:0] stream[$];
    int          req_idx, drop_req;
    bit          rand_valid;
    int          cnt_vs, cnt_rdy, cnt_fd;

    function automatic bit href_at(input int p);
        int line, col;
        if (p < 0 || p >= FRAME_T) return 1'b0;
        line = p / LINE_T;
        col  = p % LINE_T;
        return (line >= VS_LINES + V_BACK) && (line < VS_LINES + V_BACK + IMAGE_H) && (col < 2 * IMAGE_W);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, pos);
        end
    endtask

    task automatic step();
        logic [7:0] exp_data;
        logic       exp_vs, exp_fd;
        if (m_ready) begin
            if (req_idx == drop_req)  pix_valid = 1'b0;
            else if (rand_valid)      pix_valid = ($urandom_range(3) != 0);
            else                      pix_valid = 1'b1;
            pix_data = (stream.size() > 0) ? stream.pop_front() : 16'($urandom);
            req_idx++;
        end else begin
            pix_valid = rand_valid ? 1'($urandom) : 1'b1;
            pix_data  = 16'($urandom);
        end
        @(posedge clk);
        if (!rst_n) begin
            pos  = -1;
            m_uf = 1'b0;
            m_pix = 16'h0000;
        end else begin
            if (m_ready) begin
                m_pix = pix_valid ? pix_data : 16'h0000;
                if (!pix_valid) m_uf = 1'b1;
            end
            if (pos < 0 || pos == FRAME_T - 1) pos = enable ? 0 : -1;
            else                               pos++;
            if (pos == 0) req_idx = 0;
        end
        m_ready = href_at(pos + 1) && (((pos + 1) % LINE_T) % 2 == 0);
        #1;
        if (href_at(pos)) exp_data = ((pos % LINE_T) % 2 == 0) ? m_pix[15:8] : m_pix[7:0];
        else              exp_data = 8'h00;
        exp_vs = (pos >= 0) && (pos < VS_LINES * LINE_T);
        exp_fd = (pos == FRAME_T - 1);
        check("vsync",      16'(cmos_vsync), 16'(exp_vs));
        check("href",       16'(cmos_href),  16'(href_at(pos)));
        check("data",       16'(cmos_data),  16'(exp_data));
        check("pix_ready",  16'(pix_ready),  16'(m_ready));
        check("frame_done", 16'(frame_done), 16'(exp_fd));
        check("underflow",  16'(underflow),  16'(m_uf));
        if (cmos_vsync) cnt_vs++;
        if (pix_ready)  cnt_rdy++;
        if (frame_done) cnt_fd++;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 16'h0000;
        pos        = -1;
        m_ready    = 1'b0;
        m_uf       = 1'b0;
        m_pix      = 16'h0000;
        req_idx    = 0;
        drop_req   = -1;
        rand_valid = 1'b0;
        stream     = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};

        // Reset, then idle with enable low
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Frame 1: directed pixel stream, valid held high
        enable  = 1'b1;
        cnt_vs  = 0;
        cnt_rdy = 0;
        cnt_fd  = 0;
        repeat (FRAME_T) step();
        check("vs_cycles",    16'(cnt_vs),  16'(VS_LINES * LINE_T));
        check("ready_pulses", 16'(cnt_rdy), 16'(IMAGE_W * IMAGE_H));
        check("fd_count",     16'(cnt_fd),  16'd1);
        step();
        check("vsync_restart", 16'(cmos_vsync), 16'd1);

        // Frame 2: third pixel request starved
        drop_req = 2;
        for (int i = 1; i < FRAME_T; i++) begin
            step();
            if (pos == (VS_LINES + V_BACK) * LINE_T + 4 || pos == (VS_LINES + V_BACK) * LINE_T + 5)
                check("uf_slot_zero", 16'(cmos_data), 16'h0000);
        end
        drop_req = -1;
        check("underflow_sticky", 16'(underflow), 16'd1);

        // Frame 3: random pixel_valid
        rand_valid = 1'b1;
        repeat (FRAME_T) step();
        rand_valid = 1'b0;

        // Frame 4: enable dropped during ACTIVE
        for (int g = 0; g < 4 * FRAME_T && pos != 30; g++) step();
        check("reach_active", 16'(pos), 16'd30);
        enable = 1'b0;
        cnt_fd = 0;
        for (int g = 0; g < 2 * FRAME_T && pos != -1; g++) step();
        check("drop_fd_count", 16'(cnt_fd), 16'd1);
        cnt_vs = 0;
        repeat (20) step();
        check("vsync_stays_low", 16'(cnt_vs), 16'd0);

        // Reset pulse mid-line
        enable = 1'b1;
        for (int g = 0; g < 2 * FRAME_T && pos != 28; g++) step();
        check("reach_midline", 16'(pos), 16'd28);
        rst_n = 1'b0;
        step();
        check("rst_href",  16'(cmos_href),  16'd0);
        check("rst_data",  16'(cmos_data),  16'd0);
        check("rst_ready", 16'(pix_ready),  16'd0);
        check("rst_uf",    16'(underflow),  16'd0);
        rst_n = 1'b1;
        step();
        check("rst_vsync_rise", 16'(cmos_vsync), 16'd1);
        repeat (FRAME_T) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
